// File: rtl/pattern_gen_if.sv
// Control/pattern bundle between a stimulus driver and pattern_gen.
// master drives the controls, slave returns the registered pattern.
interface pattern_gen_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             en;
  logic [1:0]       mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] y;
  logic             wrap;

  modport master (
    output en, mode, load, load_val,
    input  y, wrap
  );

  modport slave (
    input  en, mode, load, load_val,
    output y, wrap
  );
endinterface

// File: rtl/pattern_gen.sv
// Registered constant/pattern source: hold, count, rotate or toggle
// a programmable reset value, with a one-cycle wrap pulse.
module pattern_gen #(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] STEP  = WIDTH'(1)
) (
  input logic          clk,
  input logic          rst,
  pattern_gen_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] ROT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    M_HOLD = 2'b00,
    M_INC  = 2'b01,
    M_ROTL = 2'b10,
    M_TOG  = 2'b11
  } mode_e;

  logic [WIDTH-1:0] y_q, y_d;
  logic             wrap_q, wrap_d;
  logic [CW-1:0]    rot_q, rot_d;
  logic             phase_q, phase_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH:0]   sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q     <= INIT;
      wrap_q  <= 1'b0;
      rot_q   <= '0;
      phase_q <= 1'b0;
      mode_q  <= 2'b00;
    end else begin
      y_q     <= y_d;
      wrap_q  <= wrap_d;
      rot_q   <= rot_d;
      phase_q <= phase_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    y_d     = y_q;
    wrap_d  = 1'b0;
    rot_d   = rot_q;
    phase_d = phase_q;
    mode_d  = bus.mode;
    sum     = {1'b0, y_q} + {1'b0, STEP};
    if (bus.load) begin
      y_d     = bus.load_val;
      rot_d   = '0;
      phase_d = 1'b0;
    end else begin
      // a mode change restarts the sequence before this cycle's step
      if (bus.mode != mode_q) begin
        rot_d   = '0;
        phase_d = 1'b0;
      end
      if (bus.en) begin
        unique case (mode_e'(bus.mode))
          M_HOLD: y_d = y_q;
          M_INC: begin
            y_d    = sum[WIDTH-1:0];
            wrap_d = sum[WIDTH];
          end
          M_ROTL: begin
            y_d = {y_q[WIDTH-2:0], y_q[WIDTH-1]};
            if (rot_d == ROT_LAST) begin
              wrap_d = 1'b1;
              rot_d  = '0;
            end else begin
              rot_d = rot_d + CW'(1);
            end
          end
          M_TOG: begin
            y_d     = ~y_q;
            wrap_d  = phase_d;
            phase_d = ~phase_d;
          end
          default: y_d = y_q;
        endcase
      end
    end
  end

  assign bus.y    = y_q;
  assign bus.wrap = wrap_q;

endmodule
